// File: rtl/motion_pkg.sv
// Shared types and default timing for the motion command scheduler.
//   motion_e        : motion code, one value per UART sender instance
//   sched_state_e   : scheduler FSM states
//   *_DEF           : default timing constants at 50 MHz
//   sanitize_motion : maps codes outside the sender range onto MOT_STOP
package motion_pkg;

    typedef enum logic [2:0] {
        MOT_STOP  = 3'd0,
        MOT_FWD   = 3'd1,
        MOT_LEFT  = 3'd2,
        MOT_RIGHT = 3'd3,
        MOT_BACK  = 3'd4
    } motion_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RESTART,
        ST_HOLDOFF,
        ST_WAIT_DONE
    } sched_state_e;

    localparam int unsigned NUM_CMDS_DEF       = 5;
    localparam int unsigned STABLE_CYCLES_DEF  = 1_000_000;
    localparam int unsigned MIN_BUSY_DEF       = 4;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 250_000;
    localparam int unsigned RESEND_CYCLES_DEF  = 10_000_000;

    function automatic motion_e sanitize_motion(input logic [2:0] code,
                                                input int unsigned num_cmds);
        if ({29'd0, code} < num_cmds) return motion_e'(code);
        return MOT_STOP;
    endfunction

endpackage

// File: rtl/motion_stability_filter.sv
// Debounces the motion request coming from the camera/FFT decision logic.
// A request is accepted once its (sanitized) value has been seen on
// STABLE_CYCLES consecutive clocks; any change restarts the run.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   req_motion   : raw request code (codes >= NUM_CMDS act as MOT_STOP)
//   accepted     : last accepted motion, MOT_STOP after reset
//   changed      : 1-cycle strobe, high in the cycle accepted takes a new value
module motion_stability_filter
    import motion_pkg::*;
#(
    parameter int unsigned NUM_CMDS      = NUM_CMDS_DEF,
    parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req_motion,
    output motion_e    accepted,
    output logic       changed
);

    localparam int unsigned    CNT_W   = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

    motion_e          req_s;
    motion_e          cand;
    logic [CNT_W-1:0] run_cnt;
    logic [CNT_W-1:0] run_cnt_nxt;

    // run_cnt_nxt counts the current sample, so a run of STABLE_CYCLES
    // matching samples reaches CNT_MAX on the last of them.
    always_comb begin
        req_s = sanitize_motion(req_motion, NUM_CMDS);
        if (req_s != cand)
            run_cnt_nxt = CNT_W'(1);
        else if (run_cnt == CNT_MAX)
            run_cnt_nxt = run_cnt;
        else
            run_cnt_nxt = run_cnt + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cand     <= MOT_STOP;
            run_cnt  <= '0;
            accepted <= MOT_STOP;
            changed  <= 1'b0;
        end else begin
            cand    <= req_s;
            run_cnt <= run_cnt_nxt;
            changed <= 1'b0;
            if (run_cnt_nxt == CNT_MAX && req_s != accepted) begin
                accepted <= req_s;
                changed  <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/motion_cmd_scheduler.sv
// Restarts exactly one JSON UART sender at a time for the accepted motion
// and steers that sender's serial output to the rover. A message in flight
// is never interrupted; a newer request is remembered and sent afterwards.
// Optional feature: define MOTION_HEARTBEAT_EN to resend the active command
// every RESEND_CYCLES while idle (the rover halts without periodic commands).
// Ports:
//   clk, rst     : clock (50 MHz), synchronous active-high reset
//   req_motion   : requested motion code
//   cmd_ready    : per-sender "message done", bit i = motion_e value i
//   uart_in      : per-sender serial output
//   cmd_restart  : one-hot 1-cycle pulse into the selected sender's reset
//   uart_out     : muxed serial line, idle-high while no message is in flight
//   active_cmd   : motion currently selected or last sent
//   busy         : a message is in flight
//   timeout_err  : sticky, a sender never reported done
//
// state        | meaning
// -------------+---------------------------------------------------------
// ST_IDLE      | line idle; start a send on new motion, pending or heartbeat
// ST_RESTART   | cmd_restart pulse to the selected sender
// ST_HOLDOFF   | MIN_BUSY cycles ignoring the sender's stale ready
// ST_WAIT_DONE | wait for cmd_ready[active_cmd] or TIMEOUT_CYCLES
module motion_cmd_scheduler
    import motion_pkg::*;
#(
    parameter int unsigned NUM_CMDS       = NUM_CMDS_DEF,
    parameter int unsigned STABLE_CYCLES  = STABLE_CYCLES_DEF,
    parameter int unsigned MIN_BUSY       = MIN_BUSY_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
`ifdef MOTION_HEARTBEAT_EN
    ,
    parameter int unsigned RESEND_CYCLES  = RESEND_CYCLES_DEF
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2:0]          req_motion,
    input  logic [NUM_CMDS-1:0] cmd_ready,
    input  logic [NUM_CMDS-1:0] uart_in,
    output logic [NUM_CMDS-1:0] cmd_restart,
    output logic                uart_out,
    output motion_e             active_cmd,
    output logic                busy,
    output logic                timeout_err
);

    localparam int unsigned       HOLD_W    = $clog2(MIN_BUSY + 1);
    localparam int unsigned       TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MIN_BUSY - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

    motion_e           accepted;
    logic              accept_chg;
    sched_state_e      state;
    logic              pending;
    logic [HOLD_W-1:0] hold_cnt;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              hb_due;

    motion_stability_filter #(
        .NUM_CMDS      (NUM_CMDS),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filter (
        .clk        (clk),
        .rst        (rst),
        .req_motion (req_motion),
        .accepted   (accepted),
        .changed    (accept_chg)
    );

`ifdef MOTION_HEARTBEAT_EN
    localparam int unsigned     HB_W   = $clog2(RESEND_CYCLES + 1);
    localparam logic [HB_W-1:0] HB_MAX = HB_W'(RESEND_CYCLES);

    logic [HB_W-1:0] hb_cnt;

    always_ff @(posedge clk) begin
        if (rst)
            hb_cnt <= '0;
        else if (state == ST_RESTART)
            hb_cnt <= '0;
        else if (hb_cnt != HB_MAX)
            hb_cnt <= hb_cnt + HB_W'(1);
    end

    assign hb_due = (hb_cnt == HB_MAX);
`else
    assign hb_due = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            active_cmd  <= MOT_STOP;
            cmd_restart <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            pending     <= 1'b1;    // forces the post-reset STOP message
            hold_cnt    <= '0;
            tmo_cnt     <= '0;
        end else begin
            cmd_restart <= '0;
            // Only the latest request matters; the flag just guarantees a
            // send even when the motion returned to the one in flight.
            if (accept_chg && state != ST_IDLE)
                pending <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (pending || accepted != active_cmd || hb_due) begin
                        active_cmd            <= accepted;
                        cmd_restart[accepted] <= 1'b1;
                        busy                  <= 1'b1;
                        pending               <= 1'b0;
                        state                 <= ST_RESTART;
                    end
                end
                ST_RESTART: begin
                    hold_cnt <= '0;
                    state    <= ST_HOLDOFF;
                end
                ST_HOLDOFF: begin
                    if (hold_cnt == HOLD_LAST) begin
                        tmo_cnt <= '0;
                        state   <= ST_WAIT_DONE;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                ST_WAIT_DONE: begin
                    // Completion is tested first so it wins over a
                    // simultaneous timeout.
                    if (cmd_ready[active_cmd]) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        busy        <= 1'b0;
                        timeout_err <= 1'b1;
                        state       <= ST_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Forcing idle-high outside a send hides select changes from the rover.
    assign uart_out = (state == ST_IDLE) ? 1'b1 : uart_in[active_cmd];

endmodule
